// File: rtl/sdma_sdp_pkg.sv
// rtl/sdma_sdp_pkg.sv - shared types and constants for the SDP sequencer
package sdma_sdp_pkg;

  localparam int SDMA_SDP_DATA_W = 256;
  localparam int SDMA_SDP_NUM_W  = 16;

  // Datapath operating modes
  localparam logic [2:0] SDMA_SDP_MODE_BYPASS       = 3'd0;
  localparam logic [2:0] SDMA_SDP_MODE_AHB2CACHESEQ = 3'd1;
  localparam logic [2:0] SDMA_SDP_MODE_CACHE2AHBSEQ = 3'd2;
  localparam logic [2:0] SDMA_SDP_MODE_AHB2CACHERND = 3'd3;
  localparam logic [2:0] SDMA_SDP_MODE_CACHE2AHBRND = 3'd4;
  localparam logic [2:0] SDMA_SDP_MODE_FILL         = 3'd5;

  typedef enum logic [2:0] {
    SDP_IDLE,
    SDP_CFG,
    SDP_XFER,
    SDP_DRAIN,
    SDP_DONE
  } sdp_state_e;

endpackage

// File: rtl/sdma_sdp_tmcode_gen.sv
// rtl/sdma_sdp_tmcode_gen.sv - thermometer code of min(remaining bytes, BYTES)
module sdma_sdp_tmcode_gen #(
  parameter int NUM_W = 16,
  parameter int BYTES = 32
) (
  input  logic [NUM_W-1:0] rem_i,
  output logic [BYTES-1:0] tmcode_o
);

  logic [NUM_W-1:0] fill;

  // Clamp to one beat worth of bytes, then set every lane below that count
  always_comb begin
    fill     = (rem_i > NUM_W'(BYTES)) ? NUM_W'(BYTES) : rem_i;
    tmcode_o = '0;
    for (int k = 0; k < BYTES; k++) begin
      tmcode_o[k] = (NUM_W'(k) < fill);
    end
  end

endmodule

// File: rtl/sdma_sdp_ctrl.sv
// rtl/sdma_sdp_ctrl.sv - transfer sequencer for sdma_data_path (optional watchdog: SDMA_SDP_CTRL_WDT_EN)
module sdma_sdp_ctrl
  import sdma_sdp_pkg::*;
#(
  parameter int DATA_W  = SDMA_SDP_DATA_W,
  parameter int NUM_W   = SDMA_SDP_NUM_W,
  parameter int WDT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cmd_vld,
  output logic                o_cmd_ready,
  input  logic [2:0]          i_cmd_mode,
  input  logic [NUM_W-1:0]    i_cmd_len,
  input  logic                i_abort,
  output logic                o_done,
  output logic                o_err,
  output logic                o_sdp_en,
  output logic                o_sdp_mode_vld,
  output logic [2:0]          o_sdp_mode,
  output logic                o_sdp_transfer_pending,
  output logic [NUM_W-1:0]    o_sdp_num_of_remain_bytes,
  output logic [DATA_W/8-1:0] o_sdp_num_of_remain_bytes_tmcode,
  input  logic                i_sdp_din_vld,
  input  logic                i_sdp_din_ready,
  input  logic                i_sdp_dout_section_done
);

  localparam int               BYTES   = DATA_W / 8;
  localparam logic [NUM_W-1:0] BYTES_N = NUM_W'(BYTES);

  sdp_state_e       state_q;
  logic             ready_q, done_q, err_q, en_q, mode_vld_q;
  logic [2:0]       mode_q;
  logic [NUM_W-1:0] rem_q;
  logic             beat;
  logic             wdt_hit;

  assign beat = i_sdp_din_vld & i_sdp_din_ready;

`ifdef SDMA_SDP_CTRL_WDT_EN
  localparam int WDT_W = (WDT_CYC > 2) ? $clog2(WDT_CYC) : 1;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             wdt_active;

  assign wdt_active = (state_q == SDP_XFER) || (state_q == SDP_DRAIN);
  assign wdt_hit    = wdt_active && (wdt_q == WDT_W'(WDT_CYC - 1));

  // Count idle cycles while waiting on the datapath; any progress restarts it
  always_comb begin
    wdt_d = '0;
    if (wdt_active && !beat && !i_sdp_dout_section_done) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end
`else
  logic unused_wdt;
  assign unused_wdt = |WDT_CYC;
  assign wdt_hit    = 1'b0;
`endif

  // Sequencer FSM with all handshake outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SDP_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      mode_vld_q <= 1'b0;
      mode_q     <= '0;
      rem_q      <= '0;
    end else begin
      mode_vld_q <= 1'b0;
      case (state_q)
        SDP_IDLE: begin
          if (i_cmd_vld) begin
            ready_q <= 1'b0;
            if (i_cmd_len == '0) begin
              // Empty command completes with error without touching the datapath
              state_q <= SDP_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= SDP_CFG;
              mode_q     <= i_cmd_mode;
              rem_q      <= i_cmd_len;
              mode_vld_q <= 1'b1;
              en_q       <= 1'b1;
            end
          end
        end
        SDP_CFG: begin
          if (i_abort) begin
            state_q <= SDP_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
          end else begin
            state_q <= SDP_XFER;
          end
        end
        SDP_XFER: begin
          if (i_abort) begin
            state_q <= SDP_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
          end else if (beat) begin
            if (rem_q > BYTES_N) begin
              rem_q <= rem_q - BYTES_N;
            end else begin
              rem_q   <= '0;
              state_q <= SDP_DRAIN;
            end
          end else if (wdt_hit) begin
            state_q <= SDP_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
          end
        end
        SDP_DRAIN: begin
          if (i_abort || (wdt_hit && !i_sdp_dout_section_done)) begin
            state_q <= SDP_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
          end else if (i_sdp_dout_section_done) begin
            state_q <= SDP_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
          end
        end
        SDP_DONE: begin
          state_q <= SDP_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= SDP_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  sdma_sdp_tmcode_gen #(
    .NUM_W (NUM_W),
    .BYTES (BYTES)
  ) u_tmcode (
    .rem_i    (rem_q),
    .tmcode_o (o_sdp_num_of_remain_bytes_tmcode)
  );

  assign o_cmd_ready               = ready_q;
  assign o_done                    = done_q;
  assign o_err                     = err_q;
  assign o_sdp_en                  = en_q;
  assign o_sdp_mode_vld            = mode_vld_q;
  assign o_sdp_mode                = mode_q;
  assign o_sdp_num_of_remain_bytes = rem_q;
  assign o_sdp_transfer_pending    = (state_q == SDP_XFER) && (rem_q > BYTES_N);

endmodule

// File: tb/tb_sdma_sdp_ctrl.sv
// tb/tb_sdma_sdp_ctrl.sv - randomized scoreboard bench for sdma_sdp_ctrl
module tb_sdma_sdp_ctrl;
  import sdma_sdp_pkg::*;

  localparam int NUM_W = 16;
  localparam int BYTES = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_cmd_vld = 1'b0;
  logic              o_cmd_ready;
  logic [2:0]        i_cmd_mode = '0;
  logic [NUM_W-1:0]  i_cmd_len = '0;
  logic              i_abort = 1'b0;
  logic              o_done, o_err, o_sdp_en, o_sdp_mode_vld;
  logic [2:0]        o_sdp_mode;
  logic              o_sdp_transfer_pending;
  logic [NUM_W-1:0]  o_sdp_num_of_remain_bytes;
  logic [BYTES-1:0]  o_sdp_num_of_remain_bytes_tmcode;
  logic              i_sdp_din_vld = 1'b0;
  logic              i_sdp_din_ready = 1'b0;
  logic              i_sdp_dout_section_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit exp_err_q[$];
  logic [2:0] last_mode = '0;

  sdma_sdp_ctrl #(.DATA_W(256), .NUM_W(NUM_W), .WDT_CYC(16)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .i_cmd_vld                        (i_cmd_vld),
    .o_cmd_ready                      (o_cmd_ready),
    .i_cmd_mode                       (i_cmd_mode),
    .i_cmd_len                        (i_cmd_len),
    .i_abort                          (i_abort),
    .o_done                           (o_done),
    .o_err                            (o_err),
    .o_sdp_en                         (o_sdp_en),
    .o_sdp_mode_vld                   (o_sdp_mode_vld),
    .o_sdp_mode                       (o_sdp_mode),
    .o_sdp_transfer_pending           (o_sdp_transfer_pending),
    .o_sdp_num_of_remain_bytes        (o_sdp_num_of_remain_bytes),
    .o_sdp_num_of_remain_bytes_tmcode (o_sdp_num_of_remain_bytes_tmcode),
    .i_sdp_din_vld                    (i_sdp_din_vld),
    .i_sdp_din_ready                  (i_sdp_din_ready),
    .i_sdp_dout_section_done          (i_sdp_dout_section_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tm_exp(input int r);
    int m;
    logic [63:0] t;
    m = (r > BYTES) ? BYTES : r;
    t = (64'd1 << m) - 64'd1;
    return t[31:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   o_cmd_ready, 1);
    chk({tag, "_done"},    o_done, 0);
    chk({tag, "_err"},     o_err, 0);
    chk({tag, "_en"},      o_sdp_en, 0);
    chk({tag, "_modevld"}, o_sdp_mode_vld, 0);
    chk({tag, "_pending"}, o_sdp_transfer_pending, 0);
    chk({tag, "_mode"},    o_sdp_mode, 0);
    chk({tag, "_remain"},  o_sdp_num_of_remain_bytes, 0);
    chk({tag, "_tmcode"},  o_sdp_num_of_remain_bytes_tmcode, 0);
  endtask

  // Monitor: every completion pulse must match the next expected outcome
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (exp_err_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("done_err", o_err, exp_err_q.pop_front());
      end
    end
  end

  // Called at the negedge of the DONE cycle; leaves the bench at the next IDLE negedge
  task automatic finish_done();
    chk("done_pulse", o_done, 1);
    chk("done_en", o_sdp_en, 0);
    chk("done_ready", o_cmd_ready, 0);
    chk("done_mode_hold", o_sdp_mode, last_mode);
    i_sdp_din_vld = 1'b0;
    i_sdp_din_ready = 1'b0;
    i_sdp_dout_section_done = 1'b0;
    i_abort = ($urandom_range(0, 2) == 0);
    @(negedge clk);
    i_abort = 1'b0;
    chk("idle_ready", o_cmd_ready, 1);
    chk("idle_done", o_done, 0);
  endtask

  // abort_cyc: -1 none, 0 abort in CFG, n>0 abort at n-th XFER cycle
  // drain_mode: 0 section_done, 1 section_done with abort, 2 reset in DRAIN
  task automatic run_cmd(input logic [2:0] mode, input int len, input int pat,
                         input int abort_cyc, input int drain_mode);
    int rem, cyc, miss, wait_n;
    chk("cmd_ready", o_cmd_ready, 1);
    i_cmd_vld  = 1'b1;
    i_cmd_mode = mode;
    i_cmd_len  = NUM_W'(len);
    i_abort    = ($urandom_range(0, 3) == 0);
    if (len == 0) exp_err_q.push_back(1'b1);
    @(negedge clk);
    i_cmd_vld  = 1'b0;
    i_abort    = 1'b0;
    i_cmd_mode = 3'($urandom);
    i_cmd_len  = NUM_W'($urandom);
    if (len == 0) begin
      chk("len0_modevld", o_sdp_mode_vld, 0);
      finish_done();
      return;
    end
    last_mode = mode;
    chk("cfg_modevld", o_sdp_mode_vld, 1);
    chk("cfg_en", o_sdp_en, 1);
    chk("cfg_mode", o_sdp_mode, mode);
    chk("cfg_remain", o_sdp_num_of_remain_bytes, len);
    chk("cfg_tmcode", o_sdp_num_of_remain_bytes_tmcode, tm_exp(len));
    chk("cfg_pending", o_sdp_transfer_pending, 0);
    i_sdp_din_vld = 1'($urandom);
    i_sdp_din_ready = 1'($urandom);
    i_sdp_dout_section_done = 1'($urandom);
    if (abort_cyc == 0) begin
      i_abort = 1'b1;
      exp_err_q.push_back(1'b1);
      @(negedge clk);
      i_abort = 1'b0;
      finish_done();
      return;
    end
    rem = len;
    cyc = 1;
    miss = 0;
    while (rem > 0) begin
      @(negedge clk);
      chk("xfer_remain", o_sdp_num_of_remain_bytes, rem);
      chk("xfer_pending", o_sdp_transfer_pending, rem > BYTES);
      chk("xfer_tmcode", o_sdp_num_of_remain_bytes_tmcode, tm_exp(rem));
      chk("xfer_en", o_sdp_en, 1);
      chk("xfer_modevld", o_sdp_mode_vld, 0);
      i_sdp_dout_section_done = 1'($urandom);
      if (cyc == abort_cyc) begin
        i_abort = 1'b1;
        i_sdp_din_vld = 1'b1;
        i_sdp_din_ready = 1'b1;
        exp_err_q.push_back(1'b1);
        @(negedge clk);
        i_abort = 1'b0;
        finish_done();
        return;
      end
      case (pat)
        0: begin i_sdp_din_vld = 1'b1; i_sdp_din_ready = 1'b1; end
        1: begin i_sdp_din_vld = 1'b1; i_sdp_din_ready = (cyc % 2 == 1); end
        default: begin
          i_sdp_din_vld = 1'($urandom);
          i_sdp_din_ready = 1'($urandom);
          if (miss >= 3) begin i_sdp_din_vld = 1'b1; i_sdp_din_ready = 1'b1; end
        end
      endcase
      if (i_sdp_din_vld && i_sdp_din_ready) begin
        rem = (rem > BYTES) ? rem - BYTES : 0;
        miss = 0;
      end else begin
        miss++;
      end
      cyc++;
      if (cyc > 4000) begin
        chk("xfer_budget", 0, 1);
        return;
      end
    end
    @(negedge clk);
    i_sdp_din_vld = 1'($urandom);
    i_sdp_din_ready = 1'($urandom);
    i_sdp_dout_section_done = 1'b0;
    chk("drain_remain", o_sdp_num_of_remain_bytes, 0);
    chk("drain_pending", o_sdp_transfer_pending, 0);
    chk("drain_tmcode", o_sdp_num_of_remain_bytes_tmcode, 0);
    chk("drain_en", o_sdp_en, 1);
    wait_n = $urandom_range(0, 3);
    for (int w = 0; w < wait_n; w++) begin
      @(negedge clk);
      chk("drain_wait_en", o_sdp_en, 1);
      chk("drain_wait_remain", o_sdp_num_of_remain_bytes, 0);
    end
    if (drain_mode == 2) begin
      i_sdp_din_vld = 1'b0;
      i_sdp_din_ready = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset_vals("rst_drain");
      last_mode = '0;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    i_sdp_dout_section_done = 1'b1;
    i_abort = (drain_mode == 1);
    exp_err_q.push_back(drain_mode == 1);
    @(negedge clk);
    i_abort = 1'b0;
    finish_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    run_cmd(SDMA_SDP_MODE_AHB2CACHESEQ, 64, 0, -1, 0);
    run_cmd(SDMA_SDP_MODE_CACHE2AHBSEQ, 35, 1, -1, 0);
    run_cmd(SDMA_SDP_MODE_FILL, 0, 0, -1, 0);
    run_cmd(SDMA_SDP_MODE_AHB2CACHERND, 128, 0, 2, 0);
    run_cmd(SDMA_SDP_MODE_CACHE2AHBRND, 33, 0, -1, 1);
    run_cmd(SDMA_SDP_MODE_AHB2CACHESEQ, 32, 0, 0, 0);
    run_cmd(SDMA_SDP_MODE_BYPASS, 1, 2, -1, 0);
    run_cmd(SDMA_SDP_MODE_FILL, 70, 0, -1, 2);
    run_cmd(SDMA_SDP_MODE_AHB2CACHESEQ, 65535, 0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      int len, ab;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 300));
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_cmd(3'($urandom), len, int'($urandom_range(0, 2)), ab,
              ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

`ifdef SDMA_SDP_CTRL_WDT_EN
    begin
      int n;
      chk("wdt_ready", o_cmd_ready, 1);
      i_cmd_vld = 1'b1;
      i_cmd_mode = SDMA_SDP_MODE_AHB2CACHESEQ;
      i_cmd_len = 16'd100;
      exp_err_q.push_back(1'b1);
      last_mode = SDMA_SDP_MODE_AHB2CACHESEQ;
      @(negedge clk);
      i_cmd_vld = 1'b0;
      @(negedge clk);
      n = 0;
      while (!o_done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("wdt_within_17", (n <= 17), 1);
      finish_done();
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdma_sdp_ctrl.md
# sdma_sdp_ctrl

Sequencer for `sdma_data_path`. Accepts one transfer command (mode and byte length), configures the datapath, and tracks accepted input beats. While beats are accepted it drives the running remaining-byte count, the last-beat thermometer code and the `transfer_pending` flag. It then waits for the datapath's section-done indication and reports completion upstream. It sits between the SDMA channel scheduler and `sdma_data_path`, one instance per datapath.

## Interface
Parameters:
- DATA_W, 256, datapath data width in bits; BYTES = DATA_W/8 (32)
- NUM_W, 16, width of the byte-length/remaining-byte fields
- WDT_CYC, 1024, watchdog limit in cycles (used only with the watchdog macro)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_cmd_vld  in  1  command valid
- o_cmd_ready  out  1  command ready; high only in IDLE
- i_cmd_mode  in  3  SDP mode (SDMA_SDP_MODE_* encoding)
- i_cmd_len  in  NUM_W  transfer length in bytes
- i_abort  in  1  abort the current transfer
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  error qualifier; valid with o_done
- o_sdp_en  out  1  datapath enable
- o_sdp_mode_vld  out  1  mode strobe to the datapath
- o_sdp_mode  out  3  mode to the datapath
- o_sdp_transfer_pending  out  1  more beats follow the current one
- o_sdp_num_of_remain_bytes  out  NUM_W  bytes not yet accepted
- o_sdp_num_of_remain_bytes_tmcode  out  BYTES  thermometer code of min(remaining, BYTES)
- i_sdp_din_vld  in  1  snooped datapath input valid
- i_sdp_din_ready  in  1  snooped datapath input ready
- i_sdp_dout_section_done  in  1  datapath section complete

## Operation
- States: IDLE, CFG, XFER, DRAIN, DONE.
- IDLE
  - o_cmd_ready=1.
  - On i_cmd_vld with len≠0: latch mode, set rem=len, go to CFG.
  - On i_cmd_vld with len=0: go to DONE with err=1; the datapath is untouched.
- CFG
  - One cycle. o_sdp_mode_vld=1, o_sdp_en=1. Go to XFER.
- XFER
  - A beat is i_sdp_din_vld & i_sdp_din_ready.
  - On a beat with rem>BYTES: rem -= BYTES.
  - On a beat with rem≤BYTES: rem=0, go to DRAIN.
- DRAIN
  - Wait for i_sdp_dout_section_done, then go to DONE.
- DONE
  - One cycle. o_done=1; o_err as latched; o_sdp_en=0. Go to IDLE.
- Output decode:
  - o_sdp_transfer_pending = (state==XFER) & (rem>BYTES).
  - tmcode bit k = (k < min(rem,BYTES)); all zeros when rem=0.
  - Example: rem=3 gives 0x...07.
- o_sdp_en is high in CFG, XFER and DRAIN.
- o_sdp_mode holds the latched mode until the next command.
- i_abort in CFG, XFER or DRAIN: go to DONE with err=1. i_abort in IDLE or DONE is ignored.
- A section_done received outside DRAIN is ignored.
- A beat seen in any state other than XFER is ignored and does not change rem.
- Arithmetic: rem is an unsigned NUM_W-bit value and never underflows (it is clamped at 0).

## Timing
- Reset values of all outputs:
  - o_cmd_ready=1.
  - o_done, o_err, o_sdp_en, o_sdp_mode_vld, o_sdp_transfer_pending = 0.
  - mode=0, remain=0, tmcode=0.
- Cycle sequence, with the command accepted at edge 0:
  - CFG during cycle 1.
  - XFER from cycle 2.
  - Beats are counted from cycle 2 onward.
- rem updates at the edge that samples the beat, so outputs reflect the new value in the following cycle.
- After section_done is sampled in DRAIN, o_done is high in the next cycle.
- Back-to-back commands: a new command is accepted in the first IDLE cycle after DONE. There is no combinational path from i_cmd_vld to o_cmd_ready.
- Simultaneous events:
  - Abort in the same cycle as the last beat: abort wins, err=1.
  - Abort in the same cycle as section_done in DRAIN: abort wins, err=1.
- Reset asserted mid-transfer: everything returns to IDLE asynchronously and no o_done is issued.

## Configuration
- SDMA_SDP_CTRL_WDT_EN defined:
  - A watchdog counter runs in XFER and DRAIN.
  - It clears on every beat and on section_done.
  - On reaching WDT_CYC-1, the block goes to DONE with err=1 and o_sdp_en drops.
- SDMA_SDP_CTRL_WDT_EN undefined:
  - No counter is built.
  - o_err is set only by len=0 or abort.
  - The block can wait indefinitely in XFER or DRAIN.

## Structure
- Package sdma_sdp_pkg holds:
  - The state enum.
  - SDMA_SDP_MODE_* encodings, including SDMA_SDP_MODE_AHB2CACHESEQ.
  - The default DATA_W/NUM_W constants.
- Sub-module sdma_sdp_tmcode_gen: combinational conversion of min(rem,BYTES) into the BYTES-wide thermometer code.

## Test plan
- Command len=64, mode AHB2CACHESEQ, beats every cycle:
  - o_sdp_mode_vld pulses once in cycle 1.
  - Remaining goes 64→32→0.
  - pending is 1 only while remaining is 64.
  - section_done in DRAIN gives o_done=1, o_err=0 the next cycle.
- len=35 with ready toggling 1/0:
  - Remaining goes 35→3.
  - tmcode is 0xFFFFFFFF at 35 and 0x00000007 at 3.
  - Exactly 2 beats are counted; ready-low cycles are ignored.
- len=0: o_cmd_ready drops for 1 cycle, then o_done=1 and o_err=1. o_sdp_en and o_sdp_mode_vld never assert.
- i_abort during XFER with remaining 96:
  - Next cycle o_done=1, o_err=1, o_sdp_en=0.
  - IDLE follows, and a new command is accepted.
- rst asserted in DRAIN: all outputs immediately take their reset values and no o_done is seen.
- With SDMA_SDP_CTRL_WDT_EN and WDT_CYC=16, no beats after CFG: o_done=1, o_err=1 within 17 cycles of entering XFER.
